timers_ctrl: RTL and testbench
==============================

// Module: timers_ctrl
// PURPOSE
//  Timer-subsystem controller above timer0/timer1/timer2. Derives the machine-cycle strobe
//  from the core clock and sequences the timers' reset release. Owns the TF0/TF1/TF2
//  flags: hardware set, CPU write, interrupt-ack clear. Arbitrates pending flags into a
//  single interrupt request/acknowledge handshake toward the interrupt controller.
// PARAMETERS
//  CYCLE_DIV   12  core clocks per machine cycle (>=1)
//  CNT_W       4   prescaler counter width; 2**CNT_W >= CYCLE_DIV
//  ROUND_ROBIN 0   0: fixed priority TF0>TF1>TF2; 1: rotate, starting after last grant
// PORTS
//  timers_ctrl_clock_i          in   1  core clock, all logic on posedge
//  timers_ctrl_reset_i          in   1  asynchronous, active-high reset
//  timers_ctrl_run_i            in   1  prescaler enable
//  timers_ctrl_ovf_i            in   3  overflow pulses [0]=T0 [1]=T1 [2]=T2, 1 clk wide
//  timers_ctrl_tf_wr_i          in   1  CPU write strobe for the TF bits
//  timers_ctrl_tf_wdata_i       in   3  CPU write data for TF2..TF0
//  timers_ctrl_int_ack_i        in   1  interrupt acknowledge, 1 clk pulse
//  timers_ctrl_machine_cycle_o  out  1  machine-cycle strobe, 1 clk wide
//  timers_ctrl_timer_reset_b_o  out  1  active-low reset to the timer instances
//  timers_ctrl_tf_o             out  3  TF2..TF0 flag state
//  timers_ctrl_int_req_o        out  1  interrupt request
//  timers_ctrl_int_id_o         out  2  granted source: 0=T0, 1=T1, 2=T2; never 3
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//   - div_cnt=0; machine_cycle_o=0; timer_reset_b_o=0; tf_o=0
//   - int_req_o=0; int_id_o=0; FSM=IDLE; rr pointer=2, so the first rotating grant is T0
//  Prescaler:
//   - run=1: div_cnt increments each clk and wraps CYCLE_DIV-1 -> 0.
//   - machine_cycle_o is registered; it is 1 for the clk after div_cnt==CYCLE_DIV-1 with run=1.
//   - CYCLE_DIV=1: strobe is constantly 1 while run=1.
//   - run=0: div_cnt holds, no strobe. Strobe resumes when div_cnt completes the count.
//  Reset release:
//   - timer_reset_b_o goes 1 at the edge where machine_cycle_o==1 (the first strobe after reset).
//   - It then stays 1 until the next reset.
//  TF flags (per bit i, priority order at each edge):
//   - 1. ovf_i[i]=1 -> tf[i]=1 (hardware set beats CPU clear and beats ack)
//   - 2. tf_wr_i=1 -> tf[i]=tf_wdata_i[i] (a CPU write of 1 is a software interrupt)
//   - 3. ack accepted and i==int_id -> tf[i]=0
//   - 4. otherwise hold
//  Arbiter FSM:
//   - IDLE, |tf_o=1: latch int_id (fixed or rotating priority); -> REQ; int_req_o=1 next clk.
//   - REQ: int_req_o=1. int_id_o is stable for the whole request.
//   - REQ, int_ack_i=1: clear tf[int_id] per the rules above; update rr pointer=int_id; -> IDLE.
//   - REQ, tf[int_id]=0 because of a CPU write: withdraw -> IDLE, no ack needed.
//   - IDLE always lasts at least 1 clk, so int_req_o drops between grants.
//   - int_ack_i outside REQ: ignored.
//  Latency:
//   - ovf_i at edge n -> tf_o=1 after edge n; int_req_o=1 after edge n+1.
//   - ack at edge m -> int_req_o=0 after edge m.
//  Simultaneous ovf on several timers: all flags set; they are granted one at a time.
// TESTING
//  - Reset, run=1, CYCLE_DIV=12 -> strobe every 12 clks; timer_reset_b_o rises on the 1st strobe.
//    run=0 mid-count freezes div_cnt.
//  - ovf_i=3'b110 in one clk, fixed priority -> int_id 1, ack, then int_id 2, ack.
//    tf_o ends at 0; int_req_o low >=1 clk between grants.
//  - ROUND_ROBIN=1, tf held 3'b111 by repeated ovf -> grant order 0,1,2,0.
//  - tf_wr_i=1 with wdata=000 and ovf_i=001 in the same clk -> tf_o=001.
//    Ack coinciding with ovf on the granted bit -> that flag stays 1.
//  - In REQ for T1, CPU writes tf=000 -> int_req_o=0 next clk with no ack.
//    Later tf_wr_i with wdata=100 -> request with int_id=2.
//  - Reset asserted while in REQ -> int_req_o, tf_o and timer_reset_b_o go 0 immediately,
//    without a clock edge.

Source files
------------

// File: rtl/timers_ctrl.sv
// Timer-subsystem controller: machine-cycle prescaler, timer reset release,
// TF0..TF2 flag ownership and single-channel interrupt request arbitration.
module timers_ctrl #(
  parameter int unsigned CYCLE_DIV   = 12,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic       timers_ctrl_clock_i,
  input  logic       timers_ctrl_reset_i,
  input  logic       timers_ctrl_run_i,
  input  logic [2:0] timers_ctrl_ovf_i,
  input  logic       timers_ctrl_tf_wr_i,
  input  logic [2:0] timers_ctrl_tf_wdata_i,
  input  logic       timers_ctrl_int_ack_i,
  output logic       timers_ctrl_machine_cycle_o,
  output logic       timers_ctrl_timer_reset_b_o,
  output logic [2:0] timers_ctrl_tf_o,
  output logic       timers_ctrl_int_req_o,
  output logic [1:0] timers_ctrl_int_id_o
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CYCLE_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             machine_cycle_q;
  logic             timer_reset_b_q;
  logic [2:0]       tf_q, tf_d;
  state_t           state_q, state_d;
  logic [1:0]       int_id_q, int_id_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       grant;
  logic [1:0]       cand;
  logic             found;
  logic             ack_ok;

  always_ff @(posedge timers_ctrl_clock_i or posedge timers_ctrl_reset_i) begin
    if (timers_ctrl_reset_i) begin
      div_cnt         <= '0;
      machine_cycle_q <= 1'b0;
      timer_reset_b_q <= 1'b0;
    end else begin
      machine_cycle_q <= timers_ctrl_run_i && (div_cnt == DIV_LAST);
      if (timers_ctrl_run_i) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
      end
      if (machine_cycle_q) begin
        timer_reset_b_q <= 1'b1;
      end
    end
  end

  assign ack_ok = (state_q == REQ) && timers_ctrl_int_ack_i;

  // Per-bit priority: hardware set, then CPU write, then acknowledge clear.
  always_comb begin
    tf_d = tf_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (timers_ctrl_ovf_i[i]) begin
        tf_d[i] = 1'b1;
      end else if (timers_ctrl_tf_wr_i) begin
        tf_d[i] = timers_ctrl_tf_wdata_i[i];
      end else if (ack_ok && (int_id_q == 2'(i))) begin
        tf_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant = '0;
    cand  = rr_q;
    found = 1'b0;
    if (ROUND_ROBIN == 0) begin
      if (tf_q[0])      grant = 2'd0;
      else if (tf_q[1]) grant = 2'd1;
      else              grant = 2'd2;
    end else begin
      // Search the three sources starting just after the last acknowledged one.
      for (int unsigned k = 0; k < 3; k++) begin
        cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        if (!found && tf_q[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (|tf_q) begin
          int_id_d = grant;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_ok) begin
          rr_d    = int_id_q;
          state_d = IDLE;
        end else if (!tf_d[int_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge timers_ctrl_clock_i or posedge timers_ctrl_reset_i) begin
    if (timers_ctrl_reset_i) begin
      state_q  <= IDLE;
      tf_q     <= '0;
      int_id_q <= '0;
      rr_q     <= 2'd2;
    end else begin
      state_q  <= state_d;
      tf_q     <= tf_d;
      int_id_q <= int_id_d;
      rr_q     <= rr_d;
    end
  end

  assign timers_ctrl_machine_cycle_o = machine_cycle_q;
  assign timers_ctrl_timer_reset_b_o = timer_reset_b_q;
  assign timers_ctrl_tf_o            = tf_q;
  assign timers_ctrl_int_req_o       = (state_q == REQ);
  assign timers_ctrl_int_id_o        = int_id_q;

endmodule

// File: tb/tb_timers_ctrl.sv
// Directed bench for timers_ctrl: fixed-priority, round-robin and single-clock
// prescaler instances share one stimulus stream.
module tb_timers_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [2:0] ovf;
  logic       tf_wr;
  logic [2:0] tf_wdata;
  logic       ack;

  logic       mc_fix, rstb_fix, req_fix;
  logic [2:0] tf_fix;
  logic [1:0] id_fix;
  logic       mc_rr, rstb_rr, req_rr;
  logic [2:0] tf_rr;
  logic [1:0] id_rr;
  logic       mc_d1, rstb_d1, req_d1;
  logic [2:0] tf_d1;
  logic [1:0] id_d1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  timers_ctrl #(.CYCLE_DIV(12), .CNT_W(4), .ROUND_ROBIN(0)) u_fix (
    .timers_ctrl_clock_i(clk), .timers_ctrl_reset_i(rst), .timers_ctrl_run_i(run),
    .timers_ctrl_ovf_i(ovf), .timers_ctrl_tf_wr_i(tf_wr), .timers_ctrl_tf_wdata_i(tf_wdata),
    .timers_ctrl_int_ack_i(ack), .timers_ctrl_machine_cycle_o(mc_fix),
    .timers_ctrl_timer_reset_b_o(rstb_fix), .timers_ctrl_tf_o(tf_fix),
    .timers_ctrl_int_req_o(req_fix), .timers_ctrl_int_id_o(id_fix));

  timers_ctrl #(.CYCLE_DIV(12), .CNT_W(4), .ROUND_ROBIN(1)) u_rr (
    .timers_ctrl_clock_i(clk), .timers_ctrl_reset_i(rst), .timers_ctrl_run_i(run),
    .timers_ctrl_ovf_i(ovf), .timers_ctrl_tf_wr_i(tf_wr), .timers_ctrl_tf_wdata_i(tf_wdata),
    .timers_ctrl_int_ack_i(ack), .timers_ctrl_machine_cycle_o(mc_rr),
    .timers_ctrl_timer_reset_b_o(rstb_rr), .timers_ctrl_tf_o(tf_rr),
    .timers_ctrl_int_req_o(req_rr), .timers_ctrl_int_id_o(id_rr));

  timers_ctrl #(.CYCLE_DIV(1), .CNT_W(1), .ROUND_ROBIN(0)) u_d1 (
    .timers_ctrl_clock_i(clk), .timers_ctrl_reset_i(rst), .timers_ctrl_run_i(run),
    .timers_ctrl_ovf_i(ovf), .timers_ctrl_tf_wr_i(tf_wr), .timers_ctrl_tf_wdata_i(tf_wdata),
    .timers_ctrl_int_ack_i(ack), .timers_ctrl_machine_cycle_o(mc_d1),
    .timers_ctrl_timer_reset_b_o(rstb_d1), .timers_ctrl_tf_o(tf_d1),
    .timers_ctrl_int_req_o(req_d1), .timers_ctrl_int_id_o(id_d1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int         seen;
  logic [1:0] rr_exp [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    rst = 1'b1; run = 1'b0; ovf = '0; tf_wr = 1'b0; tf_wdata = '0; ack = 1'b0;
    #1;
    check_eq("rst_tf", tf_fix, 3'b000);
    check_eq("rst_req", req_fix, 1'b0);
    check_eq("rst_rstb", rstb_fix, 1'b0);
    check_eq("rst_mc", mc_fix, 1'b0);
    check_eq("rst_id", id_fix, 2'd0);

    // Prescaler and reset release
    tick();
    rst = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1)  check_eq("div1_mc", mc_d1, 1'b1);
      if (k == 11) check_eq("mc_e11", mc_fix, 1'b0);
      if (k == 12) begin
        check_eq("mc_e12", mc_fix, 1'b1);
        check_eq("rstb_e12", rstb_fix, 1'b0);
      end
      if (k == 13) begin
        check_eq("mc_e13", mc_fix, 1'b0);
        check_eq("rstb_e13", rstb_fix, 1'b1);
      end
      if (k == 23) check_eq("mc_e23", mc_fix, 1'b0);
      if (k == 24) check_eq("mc_e24", mc_fix, 1'b1);
    end
    repeat (5) tick();
    run = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (mc_fix) seen++;
    end
    check_eq("freeze_no_strobe", seen, 0);
    run = 1'b1;
    repeat (6) tick();
    check_eq("resume_mc_6", mc_fix, 1'b0);
    tick();
    check_eq("resume_mc_7", mc_fix, 1'b1);

    // Two simultaneous overflows, fixed priority
    ovf = 3'b110;
    tick();
    ovf = '0;
    check_eq("ovf_tf", tf_fix, 3'b110);
    check_eq("ovf_req_lat", req_fix, 1'b0);
    tick();
    check_eq("g1_req", req_fix, 1'b1);
    check_eq("g1_id", id_fix, 2'd1);
    check_eq("g1_rr_id", id_rr, 2'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ack1_req", req_fix, 1'b0);
    check_eq("ack1_tf", tf_fix, 3'b100);
    tick();
    check_eq("g2_req", req_fix, 1'b1);
    check_eq("g2_id", id_fix, 2'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ack2_tf", tf_fix, 3'b000);
    tick();
    check_eq("idle_req", req_fix, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("stray_ack_req", req_fix, 1'b0);

    // Round robin with all flags held by repeated overflow
    do_reset();
    ovf = 3'b111;
    tick();
    for (int g = 0; g < 4; g++) begin
      tick();
      check_eq("rr_req", req_rr, 1'b1);
      check_eq("rr_id", id_rr, rr_exp[g]);
      check_eq("fix_id", id_fix, 2'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("rr_drop", req_rr, 1'b0);
      check_eq("ack_ovf_tf", tf_fix, 3'b111);
    end
    ovf = '0;

    // Hardware set beats CPU clear
    do_reset();
    tf_wr = 1'b1; tf_wdata = 3'b000; ovf = 3'b001;
    tick();
    tf_wr = 1'b0; ovf = '0;
    check_eq("set_beats_wr", tf_fix, 3'b001);

    // CPU withdraws a pending request, then raises a software interrupt
    do_reset();
    ovf = 3'b010;
    tick();
    ovf = '0;
    tick();
    check_eq("wd_req", req_fix, 1'b1);
    check_eq("wd_id", id_fix, 2'd1);
    tf_wr = 1'b1; tf_wdata = 3'b000;
    tick();
    tf_wr = 1'b0;
    check_eq("wd_drop", req_fix, 1'b0);
    check_eq("wd_tf", tf_fix, 3'b000);
    tick();
    check_eq("wd_stay", req_fix, 1'b0);
    tf_wr = 1'b1; tf_wdata = 3'b100;
    tick();
    tf_wr = 1'b0;
    check_eq("sw_tf", tf_fix, 3'b100);
    tick();
    check_eq("sw_req", req_fix, 1'b1);
    check_eq("sw_id", id_fix, 2'd2);

    // Asynchronous reset in the middle of a request
    repeat (15) tick();
    check_eq("pre_rst_req", req_fix, 1'b1);
    check_eq("pre_rst_rstb", rstb_fix, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_req", req_fix, 1'b0);
    check_eq("async_tf", tf_fix, 3'b000);
    check_eq("async_rstb", rstb_fix, 1'b0);
    check_eq("async_id", id_fix, 2'd0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
